// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and constants for the L2 port arbiter (I-cache = port 0, D-cache = port 1).
package l2_port_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} l2_arb_state_t;

    localparam int unsigned ARB_PORT_ICACHE = 0;
    localparam int unsigned ARB_PORT_DCACHE = 1;
    localparam int unsigned ARB_NPORTS      = 2;

    // Saturating increment for the optional performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bus bundle for the L2 port arbiter: both L1 requester ports on the up side, the L2 port on the mem side.
interface l2_port_arbiter_if #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned CACHE_LINE_SIZE = 512
);
    logic [1:0]                      up_req_load;
    logic [1:0]                      up_req_store;
    logic [1:0][ADDR_W-1:0]          up_addr;
    logic [1:0][CACHE_LINE_SIZE-1:0] up_wdata;
    logic [CACHE_LINE_SIZE-1:0]      up_rdata;
    logic [1:0]                      up_ready;

    logic                            mem_req_load;
    logic                            mem_req_store;
    logic [ADDR_W-1:0]               mem_addr;
    logic [CACHE_LINE_SIZE-1:0]      mem_wdata;
    logic [CACHE_LINE_SIZE-1:0]      mem_rdata;
    logic                            mem_ready;

    modport slave (
        input  up_req_load, up_req_store, up_addr, up_wdata,
        output up_rdata, up_ready,
        output mem_req_load, mem_req_store, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output up_req_load, up_req_store, up_addr, up_wdata,
        input  up_rdata, up_ready,
        input  mem_req_load, mem_req_store, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/l2_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; a tie goes to the port that did not win last time.
module rr_pick2
    import l2_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    always_comb begin
        any    = |req;
        winner = 1'(ARB_PORT_ICACHE);
        case (req)
            2'b01:   winner = 1'(ARB_PORT_ICACHE);
            2'b10:   winner = 1'(ARB_PORT_DCACHE);
            2'b11:   winner = ~last;
            default: winner = 1'(ARB_PORT_ICACHE);
        endcase
    end
endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: locks the shared L2 line port to one L1 for a whole load/store transaction.
// Define L2_ARB_PERF_EN to add saturating per-port grant and stall counters.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned CACHE_LINE_SIZE = 512
) (
    input  logic             clock,
    input  logic             reset,
    l2_port_arbiter_if.slave bus
`ifdef L2_ARB_PERF_EN
    ,
    output logic [1:0][31:0] perf_grants,
    output logic [1:0][31:0] perf_stall
`endif
);
    l2_arb_state_t              state;
    logic                       grant;
    logic                       last_grant;
    logic [1:0]                 req;
    logic                       pick;
    logic                       any;
    logic                       busy;
    logic                       done;
    logic                       sel_load;
    logic                       sel_store;
    logic [ADDR_W-1:0]          sel_addr;
    logic [CACHE_LINE_SIZE-1:0] sel_wdata;

    assign req  = bus.up_req_load | bus.up_req_store;
    assign busy = (state == ARB_BUSY);
    assign done = busy & bus.mem_ready;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_grant),
        .winner (pick),
        .any    (any)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        state      <= ARB_BUSY;
                        grant      <= pick;
                        last_grant <= pick;
                    end
                end
                ARB_BUSY: begin
                    if (bus.mem_ready) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // A granted port asking for both load and store gets its write-back done first.
    always_comb begin
        sel_load            = bus.up_req_load[grant];
        sel_store           = bus.up_req_store[grant];
        sel_addr            = bus.up_addr[grant];
        sel_wdata           = bus.up_wdata[grant];
        bus.mem_req_store   = busy & sel_store;
        bus.mem_req_load    = busy & sel_load & ~sel_store;
        bus.mem_addr        = busy ? sel_addr : '0;
        bus.mem_wdata       = busy ? sel_wdata : '0;
        bus.up_ready        = '0;
        bus.up_ready[grant] = done;
        bus.up_rdata        = done ? bus.mem_rdata : '0;
    end

`ifdef L2_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int unsigned p = 0; p < ARB_NPORTS; p++) begin
                if (!busy && any && (pick == p[0])) begin
                    perf_grants[p] <= sat_inc32(perf_grants[p]);
                end
                if (req[p] && !(busy && (grant == p[0]))) begin
                    perf_stall[p] <= sat_inc32(perf_stall[p]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a transaction-level owner model checked every cycle.
module tb_l2_port_arbiter;
    localparam int unsigned AW = 64;
    localparam int unsigned LW = 512;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    l2_port_arbiter_if #(.ADDR_W(AW), .CACHE_LINE_SIZE(LW)) bus ();

`ifdef L2_ARB_PERF_EN
    logic [1:0][31:0] perf_grants;
    logic [1:0][31:0] perf_stall;
`endif

    l2_port_arbiter #(.ADDR_W(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef L2_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: owner is the port holding the L2 port (-1 when free); prefer is who wins the next tie.
    int          owner  = -1;
    int          prefer = 0;
    int unsigned m_grants [2];
    int unsigned m_stall  [2];
    logic [1:0]  req_now;

    assign req_now = bus.up_req_load | bus.up_req_store;

    function automatic int next_owner(input logic [1:0] r, input int own, input int pref, input logic rdy);
        if (own >= 0) return rdy ? -1 : own;
        if (r == 2'b11) return pref;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner  <= -1;
            prefer <= 0;
            for (int p = 0; p < 2; p++) begin
                m_grants[p] <= 0;
                m_stall[p]  <= 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (req_now[p] && owner != p) m_stall[p] <= m_stall[p] + 1;
            end
            owner <= next_owner(req_now, owner, prefer, bus.mem_ready);
            if (owner < 0 && req_now != 2'b00) begin
                prefer <= 1 - next_owner(req_now, owner, prefer, bus.mem_ready);
                m_grants[next_owner(req_now, owner, prefer, bus.mem_ready)] <=
                    m_grants[next_owner(req_now, owner, prefer, bus.mem_ready)] + 1;
            end
            if (owner >= 0) begin
                assert (bus.mem_ready || req_now[owner[0]])
                    else $error("FAIL protocol: port %0d dropped its request while granted", owner);
            end
        end
    end

    task automatic compare_cycle();
        logic         ld;
        logic         st;
        logic         op;
        logic [63:0]  ad;
        logic [511:0] wd;
        logic [511:0] rd;
        logic [1:0]   ur;
        ld = 1'b0; st = 1'b0; ad = '0; wd = '0; rd = '0; ur = '0;
        if (owner >= 0) begin
            op = owner[0];
            st = bus.up_req_store[op];
            ld = bus.up_req_load[op] && !st;
            ad = bus.up_addr[op];
            wd = bus.up_wdata[op];
            if (bus.mem_ready) begin
                ur[op] = 1'b1;
                rd     = bus.mem_rdata;
            end
        end
        chk("cyc mem_req_load",  512'(bus.mem_req_load),  512'(ld));
        chk("cyc mem_req_store", 512'(bus.mem_req_store), 512'(st));
        chk("cyc mem_addr",      512'(bus.mem_addr),      512'(ad));
        chk("cyc mem_wdata",     bus.mem_wdata,           wd);
        chk("cyc up_ready",      512'(bus.up_ready),      512'(ur));
        chk("cyc up_rdata",      bus.up_rdata,            rd);
`ifdef L2_ARB_PERF_EN
        for (int p = 0; p < 2; p++) begin
            chk("cyc perf_grants", 512'(perf_grants[p]), 512'(m_grants[p]));
            chk("cyc perf_stall",  512'(perf_stall[p]),  512'(m_stall[p]));
        end
`endif
    endtask

    always @(negedge clock) compare_cycle();

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic p, input logic ld, input logic st,
                           input logic [63:0] a, input logic [511:0] wd);
        bus.up_req_load[p]  = ld;
        bus.up_req_store[p] = st;
        bus.up_addr[p]      = a;
        bus.up_wdata[p]     = wd;
    endtask

    task automatic expect_grant(input string name, input logic ld, input logic st, input logic [63:0] a);
        chk({name, " mem_req_load"},  512'(bus.mem_req_load),  512'(ld));
        chk({name, " mem_req_store"}, 512'(bus.mem_req_store), 512'(st));
        chk({name, " mem_addr"},      512'(bus.mem_addr),      512'(a));
        chk({name, " up_ready"},      512'(bus.up_ready),      512'(0));
    endtask

    // L2 completes the current transaction; the granted port drops its request in the IDLE gap.
    task automatic respond(input logic [511:0] rd, input logic p);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        #1;
        chk("resp up_ready", 512'(bus.up_ready), p ? 512'd2 : 512'd1);
        chk("resp up_rdata", bus.up_rdata, rd);
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        chk("gap mem_req_load",  512'(bus.mem_req_load),  512'(0));
        chk("gap mem_req_store", 512'(bus.mem_req_store), 512'(0));
        chk("gap up_ready",      512'(bus.up_ready),      512'(0));
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    logic [511:0] pat_a5;
    logic [511:0] pat_5a;
    logic [511:0] pat_c3;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_5a = {64{8'h5A}};
        pat_c3 = {64{8'hC3}};
        reset = 1'b1;
        bus.up_req_load  = '0;
        bus.up_req_store = '0;
        bus.up_addr      = '0;
        bus.up_wdata     = '0;
        bus.mem_rdata    = '0;
        bus.mem_ready    = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        chk("rst mem_req_load",  512'(bus.mem_req_load),  512'(0));
        chk("rst mem_req_store", 512'(bus.mem_req_store), 512'(0));
        chk("rst mem_addr",      512'(bus.mem_addr),      512'(0));
        chk("rst mem_wdata",     bus.mem_wdata,           '0);
        chk("rst up_ready",      512'(bus.up_ready),      512'(0));
        chk("rst up_rdata",      bus.up_rdata,            '0);
        reset = 1'b1;

        // Single port-1 fill.
        set_req(1'b1, 1'b1, 1'b0, 64'h1000, '0);
        tick();
        expect_grant("t1", 1'b1, 1'b0, 64'h1000);
        respond(pat_a5, 1'b1);

        // Tie right after reset goes to port 0, then port 1 after one IDLE cycle.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 64'h0100, '0);
        set_req(1'b1, 1'b1, 1'b0, 64'h0200, '0);
        tick();
        expect_grant("t2 first", 1'b1, 1'b0, 64'h0100);
        respond(pat_c3, 1'b0);
        tick();
        expect_grant("t2 second", 1'b1, 1'b0, 64'h0200);
        respond(pat_a5, 1'b1);

        // Store with load also raised on port 1: only the store is forwarded.
        set_req(1'b1, 1'b1, 1'b1, 64'h2040, pat_5a);
        tick();
        expect_grant("t3 store", 1'b0, 1'b1, 64'h2040);
        chk("t3 mem_wdata", bus.mem_wdata, pat_5a);
        set_req(1'b0, 1'b1, 1'b0, 64'h3000, '0);
        tick();
        expect_grant("t3 hold", 1'b0, 1'b1, 64'h2040);
        respond('0, 1'b1);
        tick();
        expect_grant("t3 port0", 1'b1, 1'b0, 64'h3000);
        respond(pat_c3, 1'b0);

        // Grant stays locked while port 1 waits; port 1 then beats a re-requesting port 0.
        set_req(1'b0, 1'b1, 1'b0, 64'h4000, '0);
        tick();
        expect_grant("t4 p0", 1'b1, 1'b0, 64'h4000);
        set_req(1'b1, 1'b1, 1'b0, 64'h5000, '0);
        tick();
        chk("t4 lock a mem_addr", 512'(bus.mem_addr), 512'(64'h4000));
        tick();
        chk("t4 lock b mem_addr", 512'(bus.mem_addr), 512'(64'h4000));
        respond(pat_a5, 1'b0);
        set_req(1'b0, 1'b1, 1'b0, 64'h4400, '0);
        tick();
        expect_grant("t4 p1", 1'b1, 1'b0, 64'h5000);
        respond(pat_5a, 1'b1);
        tick();
        expect_grant("t4 p0 again", 1'b1, 1'b0, 64'h4400);
        respond(pat_c3, 1'b0);

        // Stray mem_ready in IDLE, then asynchronous reset mid-transaction.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = pat_a5;
        #1;
        chk("t5 idle up_ready", 512'(bus.up_ready), 512'(0));
        chk("t5 idle up_rdata", bus.up_rdata, '0);
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        set_req(1'b0, 1'b1, 1'b0, 64'h6000, '0);
        tick();
        expect_grant("t5 busy", 1'b1, 1'b0, 64'h6000);
        #2 reset = 1'b0;
        #1;
        chk("t5 async mem_req_load",  512'(bus.mem_req_load),  512'(0));
        chk("t5 async mem_req_store", 512'(bus.mem_req_store), 512'(0));
        chk("t5 async mem_addr",      512'(bus.mem_addr),      512'(0));
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        reset = 1'b1;

        // Three port-0 and two port-1 transactions with both ports contending.
        set_req(1'b0, 1'b1, 1'b0, 64'h7000, '0);
        set_req(1'b1, 1'b1, 1'b0, 64'h8000, '0);
        tick();
        expect_grant("t6 a", 1'b1, 1'b0, 64'h7000);
        respond(pat_a5, 1'b0);
        set_req(1'b0, 1'b1, 1'b0, 64'h7040, '0);
        tick();
        expect_grant("t6 b", 1'b1, 1'b0, 64'h8000);
        respond(pat_5a, 1'b1);
        set_req(1'b1, 1'b1, 1'b0, 64'h8040, '0);
        tick();
        expect_grant("t6 c", 1'b1, 1'b0, 64'h7040);
        respond(pat_c3, 1'b0);
        set_req(1'b0, 1'b1, 1'b0, 64'h7080, '0);
        tick();
        expect_grant("t6 d", 1'b1, 1'b0, 64'h8040);
        respond(pat_a5, 1'b1);
        tick();
        expect_grant("t6 e", 1'b1, 1'b0, 64'h7080);
        respond(pat_5a, 1'b0);
`ifdef L2_ARB_PERF_EN
        chk("t6 perf_grants0", 512'(perf_grants[0]), 512'(3));
        chk("t6 perf_grants1", 512'(perf_grants[1]), 512'(2));
        chk("t6 perf_stall0",  512'(perf_stall[0]),  512'(7));
        chk("t6 perf_stall1",  512'(perf_stall[1]),  512'(6));
`endif
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
